adder_operand_stage: RTL
========================

# adder_operand_stage

Upstream feeder for the interface-task adder caller: accepts signed operand pairs over a valid/ready handshake and buffers them in a small FIFO. Presents the head pair combinationally to the adder caller (its `i_a`/`i_b`) and captures the returned sum (`o_a`) into a registered result slot with its own valid/ready handshake. Decouples bursty operand producers from the single-cycle combinational adder path.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `W`, 32: operand/sum width; matches `int`.
- `i_clk` in 1: sole clock. Reset is synchronous and active-high.
- `i_rst` in 1: synchronous, active-high reset.
- `i_in_valid` in 1: operand pair valid.
- `o_in_ready` out 1: stage can accept a pair this cycle.
- `i_in_a` in W: operand A, signed.
- `i_in_b` in W: operand B, signed.
- `o_op_a` out W: head operand A to the adder caller's `i_a`.
- `o_op_b` out W: head operand B to the adder caller's `i_b`.
- `i_sum` in W: adder caller's `o_a`; combinational function of `o_op_a`/`o_op_b`.
- `o_out_valid` out 1: result slot holds a sum.
- `i_out_ready` in 1: consumer takes the result.
- `o_out_sum` out W: registered sum.
- `o_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push: `i_in_valid && o_in_ready` at a rising edge writes the pair at the write pointer.
- `o_in_ready = (count < DEPTH) || pop`. A full FIFO accepts a push in the same cycle as a pop.
- `o_op_a`/`o_op_b` are the head entry when `count > 0`, otherwise 0.
- Pop condition: `pop = (count > 0) && (!o_out_valid || i_out_ready)`.
- On pop: `o_out_sum <= i_sum`, `o_out_valid <= 1`, read pointer advances.
- Drain without pop: `o_out_valid && i_out_ready && !pop` clears `o_out_valid`. `o_out_sum` holds its last value.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count is tracked separately, never derived from pointer difference.
- Sum width is W. Two's-complement wrap, unless the feature in Configuration is enabled.
- Push while `i_rst` is asserted is ignored.
- Stall: `o_out_sum` is stable while `o_out_valid && !i_out_ready`.
- `i_sum` is sampled only on a pop edge.

## Timing
- Reset values: `o_out_valid=0`, `o_out_sum=0`, `o_count=0`, pointers 0, so `o_in_ready=1`.
- `o_op_a`/`o_op_b` read 0 out of reset (FIFO empty).
- Mid-operation reset discards FIFO contents and any pending result on that edge.
- Latency: pair pushed at edge N is presented on `o_op_*` after edge N. Its sum is captured at edge N+1, so `o_out_valid` is high after N+1 (2 edges).
- Sustained throughput: 1 pair/cycle while `i_out_ready=1`.
- No combinational path from `i_in_valid` to `o_in_ready`.
- There is a combinational path from `i_out_ready` to `o_in_ready` (via pop).

## Configuration
- Macro: `ADDER_OPERAND_STAGE_SAT_EN`.
- Defined: overflow is detected as operand signs equal and sum sign different.
  - Positive overflow captures `2^(W-1)-1`.
  - Negative overflow captures `-2^(W-1)`.
  - Sticky output `o_sat_seen` (1 bit, reset 0) sets on the first saturated capture.
- Undefined: `i_sum` is captured unmodified, and no `o_sat_seen` port exists.

## Structure
- Package `adder_stage_pkg` holds:
  - `operand_t` (logic signed [31:0]);
  - `op_pair_t` struct {a, b};
  - `SAT_MAX`/`SAT_MIN` localparams.
- One sub-module, `adder_op_fifo`: a synchronous FIFO of `op_pair_t` with push/pop/count and head output.
- Result slot, pop logic and saturation stay in `adder_operand_stage`.
- At top level, `o_op_a`/`o_op_b` connect to the adder caller's `i_a`/`i_b`, and `i_sum` connects to its `o_a`.

## Test plan
- Reset, then push (3,4) with `i_out_ready=1` → after 2 edges `o_out_valid=1`, `o_out_sum=7`; next cycle `o_out_valid=0`.
- `i_out_ready=0`, push 5 pairs with DEPTH=4 → the first pair is popped into the result slot, so `o_count` reaches 4 and `o_in_ready=0` with `i_in_valid` still high. Release `i_out_ready` → sums emerge in order, one per cycle.
- Full FIFO with `i_out_ready=1` and `i_in_valid=1` every cycle → `o_in_ready=1`, `o_count` stays 4, no pair lost over 20 cycles; covers pointer wrap.
- Push (-5,2) then (100,-100) back-to-back → sums -3, then 0 on consecutive cycles.
- With `ADDER_OPERAND_STAGE_SAT_EN`, push (0x7FFFFFFF,1) → `o_out_sum=0x7FFFFFFF`, `o_sat_seen=1`. Without it → `o_out_sum=0x80000000`.
- Assert `i_rst` for one cycle with 3 entries queued and `o_out_valid=1` → after the edge `o_count=0`, `o_out_valid=0`, `o_in_ready=1`.

Source files
------------

// File: rtl/adder_stage_pkg.sv
// rtl/adder_stage_pkg.sv - shared operand types and saturation limits for the adder operand stage
package adder_stage_pkg;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_pair_t;

  // Clamp values used when saturating overflowed sums.
  localparam operand_t SAT_MAX = 32'sh7FFF_FFFF;
  localparam operand_t SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/adder_op_fifo.sv
// rtl/adder_op_fifo.sv - synchronous operand-pair FIFO with explicit occupancy count
module adder_op_fifo
  import adder_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  op_pair_t       i_data,
  input  logic           i_pop,
  output op_pair_t       o_head,
  output logic [CW-1:0]  o_count
);

  op_pair_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Next pointers wrap naturally at DEPTH (power of two); count tracked on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all queued pairs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Head entry is zero while empty so the adder sees a quiet input.
  always_comb begin
    o_head = '0;
    if (count_q != '0) o_head = mem_q[rd_ptr_q];
  end

  assign o_count = count_q;

endmodule

// File: rtl/adder_operand_stage.sv
// rtl/adder_operand_stage.sv - operand FIFO and registered result slot feeding a combinational adder (option: ADDER_OPERAND_STAGE_SAT_EN)
module adder_operand_stage
  import adder_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic signed [W-1:0]        i_in_a,
  input  logic signed [W-1:0]        i_in_b,
  output logic signed [W-1:0]        o_op_a,
  output logic signed [W-1:0]        o_op_b,
  input  logic signed [W-1:0]        i_sum,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic signed [W-1:0]        o_out_sum,
`ifdef ADDER_OPERAND_STAGE_SAT_EN
  output logic                       o_sat_seen,
`endif
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  op_pair_t            in_pair;
  op_pair_t            head_pair;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;

  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] out_sum_q,   out_sum_d;
  logic signed [W-1:0] sum_cap;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
  logic                sat_seen_q,  sat_seen_d;
  logic                ovf;
`endif

  assign in_pair.a = i_in_a;
  assign in_pair.b = i_in_b;

  // Pop whenever a pair is queued and the result slot is free or being emptied.
  always_comb begin
    pop        = (count != '0) && (!out_valid_q || i_out_ready);
    o_in_ready = (count < DEPTH_C) || pop;
    push       = i_in_valid && o_in_ready && !i_rst;
  end

  adder_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (in_pair),
    .i_pop   (pop),
    .o_head  (head_pair),
    .o_count (count)
  );

  assign o_op_a = head_pair.a;
  assign o_op_b = head_pair.b;

`ifdef ADDER_OPERAND_STAGE_SAT_EN
  // Overflow: operands share a sign the sum does not; clamp toward that sign.
  always_comb begin
    ovf     = (o_op_a[W-1] == o_op_b[W-1]) && (i_sum[W-1] != o_op_a[W-1]);
    sum_cap = i_sum;
    if (ovf) sum_cap = o_op_a[W-1] ? SAT_MIN : SAT_MAX;
  end
`else
  // Plain two's-complement wrap: the adder's sum is taken as-is.
  always_comb begin
    sum_cap = i_sum;
  end
`endif

  // Result slot next state: capture on pop, otherwise clear once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
    sat_seen_d  = sat_seen_q;
`endif
    if (pop) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_cap;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
      sat_seen_d  = sat_seen_q | ovf;
`endif
    end else if (out_valid_q && i_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result slot registers; reset drops any pending result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
      sat_seen_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
      sat_seen_q  <= sat_seen_d;
`endif
    end
  end

  assign o_out_valid = out_valid_q;
  assign o_out_sum   = out_sum_q;
  assign o_count     = count;
`ifdef ADDER_OPERAND_STAGE_SAT_EN
  assign o_sat_seen  = sat_seen_q;
`endif

endmodule
